// File: rtl/eprom_access_sched_if.sv
// Requester and controller signal bundle for the EPROM access scheduler.
// The scheduler binds the slave modport; the environment drives the master side.
interface eprom_access_sched_if #(
    parameter int unsigned M = 32
);
    logic [1:0]   req_valid;
    logic [1:0]   req_we;
    logic [M-1:0] req_wdata0;
    logic [M-1:0] req_wdata1;
    logic         cfg_margin_rd;
    logic [1:0]   req_ready;
    logic [1:0]   rsp_valid;
    logic [M-1:0] rsp_rdata;
    logic [1:0]   rsp_status;
    logic [3:0]   rsp_retries;
    logic         busy;
    logic         rd;
    logic         wr;
    logic         ack;
    logic [M-1:0] data_in;
    logic         margin_read_en;
    logic [M-1:0] data_out;
    logic         rd_done;
    logic         wr_done;

    modport slave (
        input  req_valid, req_we, req_wdata0, req_wdata1, cfg_margin_rd,
        input  data_out, rd_done, wr_done,
        output req_ready, rsp_valid, rsp_rdata, rsp_status, rsp_retries, busy,
        output rd, wr, ack, data_in, margin_read_en
    );

    modport master (
        output req_valid, req_we, req_wdata0, req_wdata1, cfg_margin_rd,
        output data_out, rd_done, wr_done,
        input  req_ready, rsp_valid, rsp_rdata, rsp_status, rsp_retries, busy,
        input  rd, wr, ack, data_in, margin_read_en
    );
endinterface

// File: rtl/eprom_access_sched.sv
// Two-port round-robin scheduler for the one-word EPROM controller, with
// program-verify-retry sequencing and a per-operation completion timeout.
module eprom_access_sched #(
    parameter int unsigned M         = 32,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 8191
) (
    input logic                 clk_div,
    input logic                 rst,
    eprom_access_sched_if.slave bus
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] RD_ISS  = 4'd1;
    localparam logic [3:0] RD_WAIT = 4'd2;
    localparam logic [3:0] WR_ISS  = 4'd3;
    localparam logic [3:0] WR_WAIT = 4'd4;
    localparam logic [3:0] VF_ISS  = 4'd5;
    localparam logic [3:0] VF_WAIT = 4'd6;
    localparam logic [3:0] CHECK   = 4'd7;
    localparam logic [3:0] RESP    = 4'd8;

    localparam logic [12:0] TMO_LAST  = 13'(TIMEOUT - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_VERIFY  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    logic [3:0]   state_q, state_d;
    logic         last_q, last_d;
    logic         own_q, own_d;
    logic [M-1:0] wbuf_q, wbuf_d;
    logic [M-1:0] rbuf_q, rbuf_d;
    logic [3:0]   retry_q, retry_d;
    logic [12:0]  tmo_q, tmo_d;
    logic [1:0]   req_ready_q, req_ready_d;
    logic [1:0]   rsp_valid_q, rsp_valid_d;
    logic [M-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]   rsp_status_q, rsp_status_d;
    logic [3:0]   rsp_retries_q, rsp_retries_d;
    logic         busy_q, busy_d;
    logic         rd_q, rd_d;
    logic         wr_q, wr_d;
    logic         ack_q, ack_d;
    logic [M-1:0] data_in_q, data_in_d;
    logic         margin_q, margin_d;

    logic         gnt;
    logic         tmo_hit;
    logic         to_resp;
    logic [1:0]   resp_code;

    always_comb begin
        // NOTE: every next-state value is defaulted before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        last_d        = last_q;
        own_d         = own_q;
        wbuf_d        = wbuf_q;
        rbuf_d        = rbuf_q;
        retry_d       = retry_q;
        tmo_d         = tmo_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_status_d  = rsp_status_q;
        rsp_retries_d = rsp_retries_q;
        data_in_d     = data_in_q;
        margin_d      = margin_q;
        req_ready_d   = 2'b00;
        rsp_valid_d   = 2'b00;
        rd_d          = 1'b0;
        wr_d          = 1'b0;
        ack_d         = 1'b0;
        to_resp       = 1'b0;
        resp_code     = ST_OK;

        gnt     = (bus.req_valid == 2'b11) ? ~last_q : bus.req_valid[1];
        tmo_hit = (tmo_q == TMO_LAST);

        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    req_ready_d[gnt] = 1'b1;
                    last_d           = gnt;
                    own_d            = gnt;
                    retry_d          = 4'd0;
                    wbuf_d           = gnt ? bus.req_wdata1 : bus.req_wdata0;
                    if (bus.req_we[gnt]) begin
                        state_d  = WR_ISS;
                        margin_d = 1'b0;
                    end else begin
                        state_d  = RD_ISS;
                        margin_d = bus.cfg_margin_rd;
                    end
                end
            end
            RD_ISS: begin
                rd_d    = 1'b1;
                tmo_d   = 13'd0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.rd_done) begin
                    rsp_rdata_d = bus.data_out;
                    ack_d       = 1'b1;
                    to_resp     = 1'b1;
                end else if (tmo_hit) begin
                    to_resp   = 1'b1;
                    resp_code = ST_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 13'd1;
                end
            end
            WR_ISS: begin
                // Retries only drive the bits the last verify found missing.
                wr_d      = 1'b1;
                data_in_d = (retry_q == 4'd0) ? wbuf_q : (wbuf_q & ~rbuf_q);
                tmo_d     = 13'd0;
                state_d   = WR_WAIT;
            end
            WR_WAIT: begin
                if (bus.wr_done) begin
                    ack_d    = 1'b1;
                    margin_d = 1'b1;
                    state_d  = VF_ISS;
                end else if (tmo_hit) begin
                    to_resp   = 1'b1;
                    resp_code = ST_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 13'd1;
                end
            end
            VF_ISS: begin
                rd_d    = 1'b1;
                tmo_d   = 13'd0;
                state_d = VF_WAIT;
            end
            VF_WAIT: begin
                if (bus.rd_done) begin
                    rbuf_d   = bus.data_out;
                    ack_d    = 1'b1;
                    margin_d = 1'b0;
                    state_d  = CHECK;
                end else if (tmo_hit) begin
                    to_resp   = 1'b1;
                    resp_code = ST_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 13'd1;
                end
            end
            CHECK: begin
                // Extra 1 bits are legal: programmed OTP bits only accumulate.
                if ((rbuf_q & wbuf_q) == wbuf_q) begin
                    rsp_rdata_d = rbuf_q;
                    to_resp     = 1'b1;
                end else if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 4'd1;
                    state_d = WR_ISS;
                end else begin
                    rsp_rdata_d = rbuf_q;
                    to_resp     = 1'b1;
                    resp_code   = ST_VERIFY;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (to_resp) begin
            state_d            = RESP;
            rsp_valid_d[own_q] = 1'b1;
            rsp_status_d       = resp_code;
            rsp_retries_d      = retry_q;
            margin_d           = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            own_q         <= 1'b0;
            wbuf_q        <= '0;
            rbuf_q        <= '0;
            retry_q       <= 4'd0;
            tmo_q         <= 13'd0;
            req_ready_q   <= 2'b00;
            rsp_valid_q   <= 2'b00;
            rsp_rdata_q   <= '0;
            rsp_status_q  <= ST_OK;
            rsp_retries_q <= 4'd0;
            busy_q        <= 1'b0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            ack_q         <= 1'b0;
            data_in_q     <= '0;
            margin_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q       <= state_d;
            last_q        <= last_d;
            own_q         <= own_d;
            wbuf_q        <= wbuf_d;
            rbuf_q        <= rbuf_d;
            retry_q       <= retry_d;
            tmo_q         <= tmo_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_status_q  <= rsp_status_d;
            rsp_retries_q <= rsp_retries_d;
            busy_q        <= busy_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            ack_q         <= ack_d;
            data_in_q     <= data_in_d;
            margin_q      <= margin_d;
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_rdata      = rsp_rdata_q;
    assign bus.rsp_status     = rsp_status_q;
    assign bus.rsp_retries    = rsp_retries_q;
    assign bus.busy           = busy_q;
    assign bus.rd             = rd_q;
    assign bus.wr             = wr_q;
    assign bus.ack            = ack_q;
    assign bus.data_in        = data_in_q;
    assign bus.margin_read_en = margin_q;

endmodule

// File: tb/tb_eprom_access_sched.sv
// Scoreboard bench for eprom_access_sched: directed requests, a behavioural
// EPROM controller, and a negedge monitor popping expected grants/responses.
module tb_eprom_access_sched;
    localparam int M         = 32;
    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT   = 8191;
    localparam int RD_LAT    = 23;

    typedef struct {
        logic        port;
        logic [1:0]  status;
        logic [31:0] rdata;
        logic [3:0]  retries;
        int          lat;
    } exp_t;

    logic clk_div = 1'b0;
    logic rst     = 1'b1;

    eprom_access_sched_if #(.M(M)) bus ();

    eprom_access_sched #(
        .M(M), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_div(clk_div),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk_div = ~clk_div;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t        exp_q[$];
    bit          gnt_exp_q[$];
    logic [31:0] wr_log[$];

    int   n_gnt = 0, n_rsp = 0, ack_cnt = 0, rd_cnt = 0;
    int   gnt_cyc[2];
    int   last_rsp_cyc = 0, last_ack_cyc = 0, wr_cyc = 0;
    bit   rd_prev = 1'b0, wr_prev = 1'b0;
    exp_t mon_e;
    int   mon_p;
    bit   mon_gp;

    logic [31:0] model_rd = '0, model_vf = '0;
    int          wr_lat = 30;
    bit          wr_hang = 1'b0;
    bit          last_rd_margin = 1'b0;

    always @(posedge clk_div) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic tick();
        @(negedge clk_div);
        #2;
    endtask

    // Monitor: samples DUT outputs on the falling edge.
    always @(negedge clk_div) begin
        if (!rst) begin
            if (bus.req_ready != 2'b00) begin
                check("gnt_onehot", 64'($countones(bus.req_ready)), 64'd1);
                mon_gp = bus.req_ready[1];
                if (gnt_exp_q.size() == 0) fail_evt("gnt_unexpected", $sformatf("port %0d", mon_gp));
                else check("gnt_port", mon_gp, gnt_exp_q.pop_front());
                gnt_cyc[mon_gp ? 1 : 0] = cyc;
                n_gnt++;
            end
            if (bus.rsp_valid != 2'b00) begin
                check("rsp_onehot", 64'($countones(bus.rsp_valid)), 64'd1);
                mon_p = bus.rsp_valid[1] ? 1 : 0;
                n_rsp++;
                last_rsp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    fail_evt("rsp_unexpected", $sformatf("port %0d", mon_p));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_port", 64'(mon_p), 64'(mon_e.port));
                    check("rsp_status", bus.rsp_status, mon_e.status);
                    check("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                    check("rsp_retries", bus.rsp_retries, mon_e.retries);
                    if (mon_e.lat >= 0) check("rsp_latency", 64'(cyc - gnt_cyc[mon_p]), 64'(mon_e.lat));
                end
            end
            if (bus.ack) begin
                ack_cnt++;
                last_ack_cyc = cyc;
            end
            if (bus.rd) rd_cnt++;
            if (bus.rd && bus.wr) fail_evt("rd_wr_overlap", "rd and wr high together");
            if (bus.rd && rd_prev) fail_evt("rd_width", "rd high two cycles");
            if (bus.wr && wr_prev) fail_evt("wr_width", "wr high two cycles");
            rd_prev = bus.rd;
            wr_prev = bus.wr;
        end else begin
            rd_prev = 1'b0;
            wr_prev = 1'b0;
        end
    end

    // Controller model, read side: rd_done 21 cycles after the rd strobe cycle.
    initial begin
        bus.rd_done  = 1'b0;
        bus.data_out = '0;
        forever begin
            @(negedge clk_div);
            if (bus.rd && !rst) begin
                last_rd_margin = bus.margin_read_en;
                repeat (21) @(posedge clk_div);
                #1;
                bus.data_out = bus.margin_read_en ? model_vf : model_rd;
                bus.rd_done  = 1'b1;
                @(posedge clk_div);
                #1 bus.rd_done = 1'b0;
            end
        end
    end

    // Controller model, write side.
    initial begin
        bus.wr_done = 1'b0;
        forever begin
            @(negedge clk_div);
            if (bus.wr && !rst) begin
                wr_log.push_back(bus.data_in);
                wr_cyc = cyc;
                if (!wr_hang) begin
                    repeat (wr_lat) @(posedge clk_div);
                    #1 bus.wr_done = 1'b1;
                    @(posedge clk_div);
                    #1 bus.wr_done = 1'b0;
                end
            end
        end
    end

    task automatic request(input bit p, input bit we, input logic [31:0] wd);
        int target = n_gnt + 1;
        int n = 0;
        bus.req_we[p] = we;
        if (p) bus.req_wdata1 = wd;
        else   bus.req_wdata0 = wd;
        bus.req_valid[p] = 1'b1;
        while (n_gnt < target && n < 200) begin
            tick();
            n++;
        end
        if (n_gnt < target) fail_evt("req_timeout", $sformatf("port %0d not granted", p));
        bus.req_valid[p] = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n = 0;
        while (n_rsp < target && n < budget) begin
            tick();
            n++;
        end
        if (n_rsp < target) fail_evt("rsp_timeout", $sformatf("got %0d responses expected %0d", n_rsp, target));
    endtask

    initial begin
        int base;
        int ack0;
        int rd0;
        bus.req_valid     = 2'b00;
        bus.req_we        = 2'b00;
        bus.req_wdata0    = '0;
        bus.req_wdata1    = '0;
        bus.cfg_margin_rd = 1'b0;

        repeat (3) @(posedge clk_div);
        #1;
        check("reset_ctrl", {bus.req_ready, bus.rsp_valid, bus.rd, bus.wr, bus.ack,
                             bus.margin_read_en, bus.busy, bus.rsp_status, bus.rsp_retries}, 64'd0);
        check("reset_rdata", bus.rsp_rdata, 64'd0);
        check("reset_data_in", bus.data_in, 64'd0);
        @(negedge clk_div);
        rst = 1'b0;
        tick();

        // Contention: both ports read continuously, grants alternate from port 0.
        model_rd = 32'h0C0C_0C0C;
        for (int i = 0; i < 4; i++) begin
            gnt_exp_q.push_back(i[0]);
            exp_q.push_back(exp_t'{port: i[0], status: 2'b00, rdata: 32'h0C0C_0C0C, retries: 4'd0, lat: RD_LAT});
        end
        base = n_gnt;
        bus.req_we    = 2'b00;
        bus.req_valid = 2'b11;
        for (int n = 0; n < 400 && n_gnt < base + 4; n++) tick();
        bus.req_valid = 2'b00;
        check("contention_grants", 64'(n_gnt - base), 64'd4);
        wait_rsp(base + 4, 200);

        // Single read on port 0, normal mode.
        model_rd = 32'hA5C3_0F11;
        gnt_exp_q.push_back(1'b0);
        exp_q.push_back(exp_t'{port: 1'b0, status: 2'b00, rdata: 32'hA5C3_0F11, retries: 4'd0, lat: RD_LAT});
        ack0 = ack_cnt;
        rd0  = rd_cnt;
        base = n_rsp;
        request(1'b0, 1'b0, 32'h0);
        wait_rsp(base + 1, 200);
        check("rd_margin", last_rd_margin, 1'b0);
        check("rd_strobes", 64'(rd_cnt - rd0), 64'd1);
        check("rd_ack_count", 64'(ack_cnt - ack0), 64'd1);
        check("rd_ack_cycle", 64'(last_ack_cyc), 64'(last_rsp_cyc));

        // Write on port 1 that verifies on the first try.
        model_vf = 32'h0000_01FF;
        wr_log.delete();
        gnt_exp_q.push_back(1'b1);
        exp_q.push_back(exp_t'{port: 1'b1, status: 2'b00, rdata: 32'h0000_01FF, retries: 4'd0, lat: -1});
        ack0 = ack_cnt;
        base = n_rsp;
        request(1'b1, 1'b1, 32'h0000_00FF);
        wait_rsp(base + 1, 500);
        check("wr1_vf_margin", last_rd_margin, 1'b1);
        check("wr1_strobes", 64'(wr_log.size()), 64'd1);
        if (wr_log.size() > 0) check("wr1_data_in", wr_log[0], 32'h0000_00FF);
        check("wr1_ack_count", 64'(ack_cnt - ack0), 64'd2);

        // Write whose top bit never sticks: three retries then verify failure.
        model_vf = 32'h7000_0001;
        wr_log.delete();
        gnt_exp_q.push_back(1'b1);
        exp_q.push_back(exp_t'{port: 1'b1, status: 2'b01, rdata: 32'h7000_0001, retries: 4'd3, lat: -1});
        ack0 = ack_cnt;
        base = n_rsp;
        request(1'b1, 1'b1, 32'hF000_0001);
        wait_rsp(base + 1, 1000);
        check("retry_strobes", 64'(wr_log.size()), 64'd4);
        if (wr_log.size() > 0) check("retry_first_data", wr_log[0], 32'hF000_0001);
        for (int i = 1; i < 4; i++)
            if (wr_log.size() > i) check($sformatf("retry_data_%0d", i), wr_log[i], 32'h8000_0000);
        check("retry_ack_count", 64'(ack_cnt - ack0), 64'd8);

        // Timeout: wr_done never arrives; rsp_rdata keeps the previous value.
        wr_hang = 1'b1;
        gnt_exp_q.push_back(1'b0);
        exp_q.push_back(exp_t'{port: 1'b0, status: 2'b10, rdata: 32'h7000_0001, retries: 4'd0, lat: TIMEOUT + 1});
        ack0 = ack_cnt;
        base = n_rsp;
        request(1'b0, 1'b1, 32'h0000_1234);
        wait_rsp(base + 1, TIMEOUT + 100);
        check("tmo_cycles", 64'(last_rsp_cyc - wr_cyc), 64'(TIMEOUT));
        check("tmo_no_ack", 64'(ack_cnt - ack0), 64'd0);
        tick();
        check("tmo_idle", bus.busy, 1'b0);
        wr_hang = 1'b0;

        // Reset during WR_WAIT; the late wr_done lands in IDLE and is ignored.
        wr_lat = 40;
        wr_log.delete();
        gnt_exp_q.push_back(1'b0);
        ack0 = ack_cnt;
        base = n_rsp;
        request(1'b0, 1'b1, 32'h0000_5555);
        for (int n = 0; n < 10 && wr_log.size() == 0; n++) tick();
        check("rstw_wr_seen", 64'(wr_log.size()), 64'd1);
        repeat (5) tick();
        check("rstw_busy_before", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rstw_ctrl", {bus.req_ready, bus.rsp_valid, bus.rd, bus.wr, bus.ack,
                            bus.margin_read_en, bus.busy, bus.rsp_status, bus.rsp_retries}, 64'd0);
        check("rstw_rdata", bus.rsp_rdata, 64'd0);
        check("rstw_data_in", bus.data_in, 64'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (60) tick();
        check("rstw_no_rsp", 64'(n_rsp - base), 64'd0);
        check("rstw_no_ack", 64'(ack_cnt - ack0), 64'd0);
        check("rstw_idle", bus.busy, 1'b0);

        // Fresh request after reset is served normally.
        model_rd = 32'h3C3C_1234;
        gnt_exp_q.push_back(1'b1);
        exp_q.push_back(exp_t'{port: 1'b1, status: 2'b00, rdata: 32'h3C3C_1234, retries: 4'd0, lat: RD_LAT});
        base = n_rsp;
        request(1'b1, 1'b0, 32'h0);
        wait_rsp(base + 1, 200);

        repeat (3) tick();
        check("sb_rsp_drained", 64'(exp_q.size()), 64'd0);
        check("sb_gnt_drained", 64'(gnt_exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
